// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, bubble encoding, opcodes, fetch FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int          PC_W     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;    // addi x0,x0,0

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register with hold and flush; flush loads a bubble (NOP, pc=0, valid=0).
// Latency: 1 cycle from pc_i/inst_i to outputs.
// Backpressure: hold_i freezes contents and takes priority over flush_i.
// Ports: clk_i, rst_n_i (async active-low), hold_i, flush_i, pc_i, inst_i,
//        pc_o, inst_o, valid_o.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int          PC_W     = cpu_pkg::PC_W,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     inst_i,
    output logic [PC_W-1:0] pc_o,
    output logic [31:0]     inst_o,
    output logic            valid_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_o    <= '0;
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
        end else if (hold_i) begin
            pc_o    <= pc_o;
            inst_o  <= inst_o;
            valid_o <= valid_o;
        end else if (flush_i) begin
            pc_o    <= '0;
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
        end else begin
            // inst_i is only captured on this path, so an X from memory during
            // idle/flush cycles never reaches the register.
            pc_o    <= pc_i;
            inst_o  <= inst_i;
            valid_o <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem address, fills the IF/ID register.
// Latency: instruction at pc is in IF/ID one edge after it is addressed; first fetch two edges after start.
// Backpressure: stall_i holds pc, IF/ID and count; branch_taken_i redirects and inserts one bubble.
// Ports: clk_i, rst_n_i (async active-low), start_i, stall_i, branch_taken_i,
//        branch_target_i, imem_addr_o, imem_inst_i, if_id_pc_o, if_id_inst_o,
//        if_id_valid_o, opcode_o, fetch_cnt_o.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          PC_W     = cpu_pkg::PC_W,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic [31:0]     imem_inst_i,
    output logic [PC_W-1:0] if_id_pc_o,
    output logic [31:0]     if_id_inst_o,
    output logic            if_id_valid_o,
    output logic [6:0]      opcode_o,
    output logic [31:0]     fetch_cnt_o
);

    localparam logic [PC_W-1:0] PC_RST = RESET_PC[PC_W-1:0];

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic            run;
    logic            hold;
    logic            flush;
    logic            unused_tgt_bits;

    // Targets are word-aligned by dropping the low bits; they are never observed.
    assign unused_tgt_bits = ^branch_target_i[1:0];

    assign run   = (state == RUN);
    // Outside RUN the stall/branch inputs are don't-care and IF/ID keeps bubbling.
    assign hold  = run && stall_i;
    assign flush = !run || branch_taken_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            pc          <= PC_RST;
            fetch_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pc <= PC_RST;
                    if (start_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stall_i) begin
                        // Branch is ignored here; ID re-asserts it once the stall clears.
                        pc <= pc;
                    end else if (branch_taken_i) begin
                        pc <= {branch_target_i[PC_W-1:2], 2'b00};
                    end else begin
                        pc          <= pc + PC_W'(4);
                        fetch_cnt_o <= fetch_cnt_o + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    pc    <= PC_RST;
                end
            endcase
        end
    end

    assign imem_addr_o = pc;

    if_id_reg #(
        .PC_W     (PC_W),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .hold_i  (hold),
        .flush_i (flush),
        .pc_i    (pc),
        .inst_i  (imem_inst_i),
        .pc_o    (if_id_pc_o),
        .inst_o  (if_id_inst_o),
        .valid_o (if_id_valid_o)
    );

    assign opcode_o = if_id_inst_o[6:0];

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode/control unit.
- Owns the PC and drives the instruction-memory address.
- Registers the fetched instruction and its PC. Presents opcode[6:0] to the decoder.
- Obeys stall from the hazard unit and branch redirect/flush from ID.

Parameters:
- PC_W, 32, width of PC and addresses.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; begins fetching.
- stall_i  in  1  load-use stall from hazard unit; hold PC and IF/ID.
- branch_taken_i  in  1  beq resolved taken in ID; redirect and flush.
- branch_target_i  in  PC_W  redirect address.
- imem_addr_o  out  PC_W  instruction-memory address, equal to pc (combinational read memory).
- imem_inst_i  in  32  instruction at imem_addr_o, same cycle.
- if_id_pc_o  out  PC_W  PC of registered instruction.
- if_id_inst_o  out  32  registered instruction.
- if_id_valid_o  out  1  1 = real instruction, 0 = bubble.
- opcode_o  out  7  if_id_inst_o[6:0], to control unit.
- fetch_cnt_o  out  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset (async, rst_n_i=0) sets:
  - state=IDLE, pc=RESET_PC, if_id_pc_o=0.
  - if_id_inst_o=NOP_INST, if_id_valid_o=0, fetch_cnt_o=0.
  - The reset values appear immediately, not on the next edge. Reset mid-operation discards all in-flight state.
- State machine has two states, IDLE and RUN.
  - IDLE: PC held at RESET_PC; IF/ID loads a bubble each cycle. stall_i and branch_taken_i are ignored.
  - IDLE -> RUN on start_i=1.
  - The first fetch occurs in the cycle after the start edge, so the instruction at RESET_PC is valid in IF/ID two edges after start_i is sampled.
  - RUN has no exit except reset. start_i is ignored in RUN.
- RUN, per rising edge, priority order:
  - 1) stall_i=1: pc, IF/ID and fetch_cnt_o hold their values. branch_taken_i is ignored, because ID keeps the branch and re-asserts it after the stall.
  - 2) branch_taken_i=1: pc <= {branch_target_i[PC_W-1:2],2'b00}. IF/ID <= bubble (NOP_INST, valid=0, pc=0). Count unchanged. Branch penalty is one bubble.
  - 3) otherwise: IF/ID <= {pc, imem_inst_i, valid=1}; pc <= pc+4, wrapping modulo 2^PC_W; fetch_cnt_o += 1, wrapping at 2^32.
- imem_addr_o = pc at all times, including during stall.
- opcode_o always equals if_id_inst_o[6:0], so a bubble presents 7'b0010011.
- Low two bits of pc are always 00. Misaligned targets are silently aligned; no exception.
- No X propagation: imem_inst_i is sampled only in case 3.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W and NOP_INST;
  - opcode constants OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011;
  - enum fetch_state_t {IDLE, RUN}.
- One natural sub-module, if_id_reg: a pipeline register with hold (stall) and flush (bubble) inputs, reused later for ID/EX.
- PC logic and the state machine stay in fetch_stage.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n_i low mid-cycle; then 5 cycles without start_i.
  - Response: outputs go to reset values asynchronously. imem_addr_o=0, if_id_valid_o=0, opcode_o=7'h13, fetch_cnt_o=0 throughout.
- Start and sequential fetch:
  - Stimulus: start_i pulse; memory returns inst = 32'h1000_0000|addr.
  - Response: if_id_pc_o steps 0,4,8,12 with matching inst and valid=1, and fetch_cnt_o=4 after 4 fetches.
- Stall:
  - Stimulus: with pc=8, assert stall_i for 2 cycles, branch_taken_i=1 simultaneously.
  - Response: pc stays 8, IF/ID and count hold, no redirect. Then stall_i=0 with branch_taken_i=0 resumes fetch at 8.
- Branch redirect:
  - Stimulus: branch_taken_i=1, target=32'h40 while pc=12.
  - Response: next edge gives IF/ID valid=0 with inst=NOP_INST, pc=0x40; the following edge gives if_id_pc_o=0x40, valid=1. Target 32'h43 is aligned to 0x40.
- Wrap-around:
  - Stimulus: branch to 32'hFFFF_FFFC, then run.
  - Response: IF/ID pc 0xFFFFFFFC, then next fetch pc=0; fetch_cnt_o preloaded near 2^32-1 wraps to 0.
- Reset mid-run:
  - Stimulus: drop rst_n_i during stall.
  - Response: immediate return to IDLE values; start_i is required again before pc leaves 0.
